// File: rtl/ex_branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_branch_pkg
//  Purpose  : Shared types and constants for EX-stage branch resolution:
//             2-bit saturating-counter encoding, JALR funct code, link
//             register number and the BHT index-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package ex_branch_pkg;

    // Branch-history counter encoding; MSB is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_cnt_e;

    localparam logic [5:0] c_funct_jalr = 6'b001001;
    localparam logic [4:0] c_link_reg   = 5'd31;

    // Number of PC bits used to select one of 'depth' counters.
    function automatic int bht_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
//  Module   : bht_2bit
//  Purpose  : Table of DEPTH 2-bit saturating branch-history counters.
//             One asynchronous read port (prediction), one write port
//             (resolution update). A same-cycle read of the index being
//             written returns the pre-update value.
//  Ports    : clk, rst (async, active-high)
//             rd_idx  / rd_cnt    - lookup index and counter value
//             wr_en / wr_idx / wr_taken - saturating inc/dec request
//  Revision : 1.0  initial release
// ============================================================================
module bht_2bit
    import ex_branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = bht_idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_e         rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_cnt_e cnt_q [DEPTH];
    bht_cnt_e cnt_d [DEPTH];
    bht_cnt_e w_cur;
    bht_cnt_e w_next;

    // Reads come straight from the flops, so there is no write bypass.
    assign rd_cnt = cnt_q[rd_idx];

    always_comb begin
        w_cur  = cnt_q[wr_idx];
        w_next = w_cur;
        if (wr_taken) begin
            if (w_cur != ST) begin
                w_next = bht_cnt_e'(w_cur + 2'd1);
            end
        end else begin
            if (w_cur != SNT) begin
                w_next = bht_cnt_e'(w_cur - 2'd1);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : ex_branch_resolve
//  Purpose  : EX-stage branch/jump resolution. Computes targets, detects
//             conditional-branch mispredictions, issues a registered
//             one-cycle redirect/flush, drives link-register writeback for
//             JAL/JALR and trains a 2-bit BHT used for IF prediction.
//  Ports    : if_pc -> if_pred_taken          (IF prediction lookup)
//             ex_valid, branch_ex, jump_ex, jump_reg_ex, cond_true,
//             pred_taken_ex, pc4_ex, rs_val_ex, imm_ext_ex,
//             instr_index_ex, rd_ex, funct_ex (EX instruction)
//             redirect_valid, redirect_pc, flush (registered)
//             link_en, link_rd_sel, pc_plus8_ex   (combinational)
//             stat_branches, stat_mispredicts     (optional counters)
//  Config   : define EX_BRANCH_STATS_EN to build saturating branch /
//             mispredict counters; otherwise the stat outputs are tied 0.
//  Revision : 1.0  initial release
// ============================================================================
module ex_branch_resolve
    import ex_branch_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            branch_ex,
    input  logic            jump_ex,
    input  logic            jump_reg_ex,
    input  logic            cond_true,
    input  logic            pred_taken_ex,
    input  logic [XLEN-1:0] pc4_ex,
    input  logic [XLEN-1:0] rs_val_ex,
    input  logic [XLEN-1:0] imm_ext_ex,
    input  logic [25:0]     instr_index_ex,
    input  logic [4:0]      rd_ex,
    input  logic [5:0]      funct_ex,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            link_en,
    output logic [4:0]      link_rd_sel,
    output logic [XLEN-1:0] pc_plus8_ex,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = bht_idx_w(BHT_DEPTH);

    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q,    redirect_pc_d;

    logic            w_live;
    logic            w_is_jr;
    logic            w_is_j;
    logic            w_is_br;
    logic            w_is_jalr;
    logic            w_mispredict;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_j_target;
    logic [XLEN-1:0] w_ex_pc;
    bht_cnt_e        w_rd_cnt;
    logic            w_unused_bits;

    // The instruction in EX during the redirect cycle is on the wrong path.
    assign w_live = ex_valid & ~redirect_valid_q;

    // Jump-register beats jump beats branch when decode flags overlap.
    assign w_is_jr   = w_live & jump_reg_ex;
    assign w_is_j    = w_live & ~jump_reg_ex & jump_ex;
    assign w_is_br   = w_live & ~jump_reg_ex & ~jump_ex & branch_ex;
    assign w_is_jalr = w_is_jr & (funct_ex == c_funct_jalr);

    assign w_mispredict = cond_true ^ pred_taken_ex;

    assign w_br_target = pc4_ex + {imm_ext_ex[XLEN-3:0], 2'b00};
    assign w_j_target  = {pc4_ex[XLEN-1:XLEN-4], instr_index_ex, 2'b00};
    assign w_ex_pc     = pc4_ex - 32'd4;

    always_comb begin
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (w_is_jr) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = rs_val_ex;
        end else if (w_is_j) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = w_j_target;
        end else if (w_is_br && w_mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = cond_true ? w_br_target : pc4_ex;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = redirect_valid_q;

    // J and JAL share jump_ex; every jump_ex instruction writes $31.
    assign link_en     = w_is_j | w_is_jalr;
    assign link_rd_sel = w_is_jalr ? rd_ex : (w_is_j ? c_link_reg : 5'd0);
    assign pc_plus8_ex = pc4_ex + 32'd4;

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_cnt   (w_rd_cnt),
        .wr_en    (w_is_br),
        .wr_idx   (w_ex_pc[IDX_W+1:2]),
        .wr_taken (cond_true)
    );

    assign if_pred_taken = w_rd_cnt[1];

    assign w_unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                             imm_ext_ex[XLEN-1:XLEN-2], w_rd_cnt[0],
                             w_ex_pc[XLEN-1:IDX_W+2], w_ex_pc[1:0]};

`ifdef EX_BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (w_is_br && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (w_is_br && w_mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_branch_resolve
//  Purpose  : Directed self-checking bench for ex_branch_resolve with
//             hand-computed expectations (BHT_DEPTH=64, index = pc[7:2]).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_branch_resolve;

`ifdef EX_BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, branch_ex, jump_ex, jump_reg_ex;
    logic        cond_true, pred_taken_ex;
    logic [31:0] pc4_ex, rs_val_ex, imm_ext_ex;
    logic [25:0] instr_index_ex;
    logic [4:0]  rd_ex;
    logic [5:0]  funct_ex;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        link_en;
    logic [4:0]  link_rd_sel;
    logic [31:0] pc_plus8_ex;
    logic [31:0] stat_branches, stat_mispredicts;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mp = 0;

    ex_branch_resolve #(.BHT_DEPTH(64), .XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .branch_ex        (branch_ex),
        .jump_ex          (jump_ex),
        .jump_reg_ex      (jump_reg_ex),
        .cond_true        (cond_true),
        .pred_taken_ex    (pred_taken_ex),
        .pc4_ex           (pc4_ex),
        .rs_val_ex        (rs_val_ex),
        .imm_ext_ex       (imm_ext_ex),
        .instr_index_ex   (instr_index_ex),
        .rd_ex            (rd_ex),
        .funct_ex         (funct_ex),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .link_en          (link_en),
        .link_rd_sel      (link_rd_sel),
        .pc_plus8_ex      (pc_plus8_ex),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_idle();
        ex_valid       = 1'b0;
        branch_ex      = 1'b0;
        jump_ex        = 1'b0;
        jump_reg_ex    = 1'b0;
        cond_true      = 1'b0;
        pred_taken_ex  = 1'b0;
        pc4_ex         = 32'h0;
        rs_val_ex      = 32'h0;
        imm_ext_ex     = 32'h0;
        instr_index_ex = 26'h0;
        rd_ex          = 5'd0;
        funct_ex       = 6'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One live conditional branch for one cycle; returns just after the edge.
    task automatic issue_branch(input logic [31:0] pc4, input logic [31:0] imm,
                                input logic cond, input logic pred);
        drive_idle();
        ex_valid      = 1'b1;
        branch_ex     = 1'b1;
        pc4_ex        = pc4;
        imm_ext_ex    = imm;
        cond_true     = cond;
        pred_taken_ex = pred;
        exp_br++;
        if (cond != pred) exp_mp++;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        if_pc = 32'h0040_0000;
        drive_idle();
        #12;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", if_pred_taken); end
        checks++; if (dut.u_bht.cnt_q[0] !== 2'd1) begin errors++; $display("FAIL reset_cnt0: got %0d want 1", dut.u_bht.cnt_q[0]); end
        checks++; if (dut.u_bht.cnt_q[63] !== 2'd1) begin errors++; $display("FAIL reset_cnt63: got %0d want 1", dut.u_bht.cnt_q[63]); end
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
        tick();
        rst = 1'b0;
        exp_br = 0;
        exp_mp = 0;
        tick();
    endtask

    task automatic test_beq_mispredict();
        if_pc = 32'h0040_0000;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL beq_pred_before: got %b want 0", if_pred_taken); end
        issue_branch(32'h0040_0004, 32'h0000_0010, 1'b1, 1'b0);
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_redirect_valid: got %b want 1", redirect_valid); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush: got %b want 1", flush); end
        checks++; if (redirect_pc !== 32'h0040_0044) begin errors++; $display("FAIL beq_redirect_pc: got %h want 00400044", redirect_pc); end
        checks++; if (dut.u_bht.cnt_q[0] !== 2'd2) begin errors++; $display("FAIL beq_cnt: got %0d want 2", dut.u_bht.cnt_q[0]); end
        checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL beq_pred_after: got %b want 1", if_pred_taken); end
        tick();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_redirect_one_cycle: got %b want 0", redirect_valid); end
    endtask

    task automatic test_bht_saturation();
        logic [1:0] exp_nt [5];
        exp_nt[0] = 2'd2; exp_nt[1] = 2'd1; exp_nt[2] = 2'd0;
        exp_nt[3] = 2'd0; exp_nt[4] = 2'd0;
        if_pc = 32'h0040_0004;
        issue_branch(32'h0040_0008, 32'h4, 1'b1, 1'b0);
        checks++; if (dut.u_bht.cnt_q[1] !== 2'd2) begin errors++; $display("FAIL sat_taken1: got %0d want 2", dut.u_bht.cnt_q[1]); end
        tick();
        issue_branch(32'h0040_0008, 32'h4, 1'b1, 1'b1);
        checks++; if (dut.u_bht.cnt_q[1] !== 2'd3) begin errors++; $display("FAIL sat_taken2: got %0d want 3", dut.u_bht.cnt_q[1]); end
        checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_pred_taken: got %b want 1", if_pred_taken); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL sat_correct_no_redirect: got %b want 0", redirect_valid); end
        for (int i = 0; i < 5; i++) begin
            issue_branch(32'h0040_0008, 32'h4, 1'b0, 1'b0);
            checks++; if (dut.u_bht.cnt_q[1] !== exp_nt[i]) begin errors++; $display("FAIL sat_not_taken_%0d: got %0d want %0d", i, dut.u_bht.cnt_q[1], exp_nt[i]); end
            checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL sat_nt_no_redirect_%0d: got %b want 0", i, redirect_valid); end
        end
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_pred_not_taken: got %b want 0", if_pred_taken); end
    endtask

    task automatic test_nottaken_mispredict();
        issue_branch(32'h0040_0018, 32'h0000_0040, 1'b0, 1'b1);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0018) begin errors++; $display("FAIL nt_mispredict: got v=%b pc=%h want v=1 pc=00400018", redirect_valid, redirect_pc); end
        checks++; if (dut.u_bht.cnt_q[5] !== 2'd0) begin errors++; $display("FAIL nt_mispredict_cnt: got %0d want 0", dut.u_bht.cnt_q[5]); end
        tick();
        issue_branch(32'h0040_001C, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0018) begin errors++; $display("FAIL neg_imm_target: got v=%b pc=%h want v=1 pc=00400018", redirect_valid, redirect_pc); end
        checks++; if (dut.u_bht.cnt_q[6] !== 2'd2) begin errors++; $display("FAIL neg_imm_cnt: got %0d want 2", dut.u_bht.cnt_q[6]); end
        tick();
    endtask

    task automatic test_jal();
        drive_idle();
        ex_valid       = 1'b1;
        jump_ex        = 1'b1;
        pc4_ex         = 32'h0040_0010;
        instr_index_ex = 26'h010_0000;
        #1;
        checks++; if (link_en !== 1'b1) begin errors++; $display("FAIL jal_link_en: got %b want 1", link_en); end
        checks++; if (link_rd_sel !== 5'd31) begin errors++; $display("FAIL jal_link_rd: got %0d want 31", link_rd_sel); end
        checks++; if (pc_plus8_ex !== 32'h0040_0014) begin errors++; $display("FAIL jal_pc_plus8: got %h want 00400014", pc_plus8_ex); end
        tick();
        drive_idle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0000) begin errors++; $display("FAIL jal_redirect: got v=%b pc=%h want v=1 pc=00400000", redirect_valid, redirect_pc); end
        tick();
    endtask

    task automatic test_jalr_shadow();
        drive_idle();
        ex_valid    = 1'b1;
        jump_reg_ex = 1'b1;
        funct_ex    = 6'b001001;
        rd_ex       = 5'd5;
        rs_val_ex   = 32'h1234_5678;
        #1;
        checks++; if (link_en !== 1'b1 || link_rd_sel !== 5'd5) begin errors++; $display("FAIL jalr_link: got en=%b rd=%0d want en=1 rd=5", link_en, link_rd_sel); end
        tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1234_5678) begin errors++; $display("FAIL jalr_redirect: got v=%b pc=%h want v=1 pc=12345678", redirect_valid, redirect_pc); end
        // Wrong-path branch in the redirect shadow.
        drive_idle();
        ex_valid   = 1'b1;
        branch_ex  = 1'b1;
        cond_true  = 1'b1;
        pc4_ex     = 32'h0040_000C;
        imm_ext_ex = 32'h10;
        tick();
        drive_idle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL shadow_redirect: got %b want 0", redirect_valid); end
        checks++; if (dut.u_bht.cnt_q[2] !== 2'd1) begin errors++; $display("FAIL shadow_cnt: got %0d want 1", dut.u_bht.cnt_q[2]); end
        checks++; if (stat_branches !== (STATS ? 32'(exp_br) : 32'd0)) begin errors++; $display("FAIL shadow_stat_br: got %0d want %0d", stat_branches, STATS ? exp_br : 0); end
        checks++; if (stat_mispredicts !== (STATS ? 32'(exp_mp) : 32'd0)) begin errors++; $display("FAIL shadow_stat_mp: got %0d want %0d", stat_mispredicts, STATS ? exp_mp : 0); end
        // Plain JR: redirects but does not link.
        ex_valid    = 1'b1;
        jump_reg_ex = 1'b1;
        funct_ex    = 6'b001000;
        rd_ex       = 5'd7;
        rs_val_ex   = 32'h0040_0100;
        #1;
        checks++; if (link_en !== 1'b0 || link_rd_sel !== 5'd0) begin errors++; $display("FAIL jr_no_link: got en=%b rd=%0d want en=0 rd=0", link_en, link_rd_sel); end
        tick();
        drive_idle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0100) begin errors++; $display("FAIL jr_redirect: got v=%b pc=%h want v=1 pc=00400100", redirect_valid, redirect_pc); end
        tick();
    endtask

    task automatic test_nonlive();
        drive_idle();
        branch_ex  = 1'b1;
        cond_true  = 1'b1;
        jump_ex    = 1'b1;
        pc4_ex     = 32'h0040_0020;
        #1;
        checks++; if (link_en !== 1'b0) begin errors++; $display("FAIL nonlive_link_en: got %b want 0", link_en); end
        tick();
        drive_idle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL nonlive_redirect: got %b want 0", redirect_valid); end
        checks++; if (dut.u_bht.cnt_q[7] !== 2'd1) begin errors++; $display("FAIL nonlive_cnt: got %0d want 1", dut.u_bht.cnt_q[7]); end
    endtask

    task automatic test_correct_taken();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_br = 0;
        exp_mp = 0;
        tick();
        issue_branch(32'h0040_0010, 32'h8, 1'b1, 1'b1);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL correct_taken_redirect: got %b want 0", redirect_valid); end
        checks++; if (dut.u_bht.cnt_q[3] !== 2'd2) begin errors++; $display("FAIL correct_taken_cnt: got %0d want 2", dut.u_bht.cnt_q[3]); end
        checks++; if (stat_branches !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL correct_taken_stat_br: got %0d want %0d", stat_branches, STATS ? 1 : 0); end
        checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL correct_taken_stat_mp: got %0d want 0", stat_mispredicts); end
    endtask

    task automatic test_reset_mid();
        int bad;
        issue_branch(32'h0040_0014, 32'h20, 1'b1, 1'b0);
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_redirect: got %b want 1", redirect_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL mid_reset_redirect: got v=%b f=%b want 0/0", redirect_valid, flush); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL mid_reset_pc: got %h want 0", redirect_pc); end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (dut.u_bht.cnt_q[i] !== 2'd1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_counters: got %0d counters not 01 want 0", bad); end
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin errors++; $display("FAIL mid_reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mid_after_release: got %b want 0", redirect_valid); end
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_bht_saturation();
        test_nottaken_mispredict();
        test_jal();
        test_jalr_shadow();
        test_nonlive();
        test_correct_taken();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
